// File: rtl/fxp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fxp_div_seq
// Purpose  : Sequential signed Q1.(WIDTH-1) fixed-point divider. It uses a
//            restoring shift-subtract loop with round-half-away-from-zero,
//            saturation and divide-by-zero flags.
// Revision : 1.0  initial release
// ============================================================================
module fxp_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             dbz
);

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-2:0] quo_q;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] amag_q, bmag_q;
    logic             sign_q, asign_q;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ovf_q, ovf_d, dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shift;
    logic             take;
    logic [WIDTH-1:0] mag;

    // Two's-complement magnitude; the most negative value maps onto itself as unsigned
    assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_CALC);
        done = (state_q == S_FIN);
    end

    always_comb begin
        shift = {rem_q, 1'b0};
        take  = (shift >= {1'b0, bmag_q});
        rem_d = take ? (shift[WIDTH-1:0] - bmag_q) : shift[WIDTH-1:0];
        quo_d = {quo_q, take};
        // (q+1)>>1 written as floor(q/2) + lsb so no carry bit is dropped
        mag   = {1'b0, quo_d[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, quo_d[0]};
    end

    always_comb begin
        y_d   = sign_q ? (~mag + 1'b1) : mag;
        ovf_d = 1'b0;
        dbz_d = 1'b0;
        if (bmag_q == '0) begin
            dbz_d = 1'b1;
            y_d   = asign_q ? MAX_NEG : MAX_POS;
        end else if (amag_q > bmag_q) begin
            ovf_d = 1'b1;
            y_d   = sign_q ? MAX_NEG : MAX_POS;
        end else if ((amag_q == bmag_q) || (mag == MAX_NEG)) begin
            // Magnitude of exactly one: representable only as -1
            ovf_d = ~sign_q;
            y_d   = sign_q ? MAX_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            amag_q  <= '0;
            bmag_q  <= '0;
            sign_q  <= 1'b0;
            asign_q <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        amag_q  <= a_mag;
                        bmag_q  <= b_mag;
                        sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                        asign_q <= A[WIDTH-1];
                        rem_q   <= a_mag;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d[WIDTH-2:0];
                    cnt_q <= cnt_q + CW'(1);
                    // Result is captured on the final iteration edge so it is valid in FIN
                    if (cnt_q == LAST) begin
                        y_q   <= y_d;
                        ovf_q <= ovf_d;
                        dbz_q <= dbz_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Y   = y_q;
    assign ovf = ovf_q;
    assign dbz = dbz_q;

endmodule
`default_nettype wire
